// File: rtl/regs_writeback.sv
// regs_writeback: serialises ALU (via FIFO) and extended load results into the register-file write port, with a busy scoreboard.
// Optional REGS_WB_BYPASS_EN adds rs1adr/rs2adr inputs and combinational fwd_rs1_hit/fwd_rs2_hit outputs.
module regs_writeback #(
    parameter int XLEN      = 32,
    parameter int ALU_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [3:0]      alu_rdadr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [3:0]      ld_rdadr,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic [XLEN-1:0] ld_word,
    output logic            ld_err,
    input  logic            issue_valid,
    input  logic [3:0]      issue_rdadr,
    output logic [15:0]     busy,
`ifdef REGS_WB_BYPASS_EN
    input  logic [3:0]      rs1adr,
    input  logic [3:0]      rs2adr,
    output logic            fwd_rs1_hit,
    output logic            fwd_rs2_hit,
`endif
    output logic            regwrite,
    output logic [3:0]      rdadr,
    output logic [XLEN-1:0] rd
);
    localparam int AW = $clog2(ALU_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(ALU_DEPTH);

    logic [XLEN-1:0] data_q [ALU_DEPTH];
    logic [3:0]      adr_q  [ALU_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [AW:0]     cnt_q;
    logic            regwrite_q, regwrite_d, ld_err_q;
    logic [3:0]      rdadr_q, sel_adr;
    logic [XLEN-1:0] rd_q, rd_d, ld_ext;
    logic [15:0]     busy_q, busy_d, set_m, clr_m;
    logic            push, pop, sel, ld_bad;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;

    assign alu_ready = cnt_q < DEPTH_C;
    assign ld_ready  = 1'b1;
    assign push      = alu_valid && alu_ready;
    assign pop       = !ld_valid && cnt_q != '0;
    assign sel       = ld_valid || pop;
    assign ld_b      = ld_word[{ld_offset, 3'b000} +: 8];
    assign ld_h      = ld_word[{ld_offset[1], 4'b0000} +: 16];

    always_comb begin
        ld_bad = 1'b0;
        ld_ext = '0;
        case (ld_funct3)
            3'b000:  ld_ext = {{(XLEN-8){ld_b[7]}}, ld_b};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_b};
            3'b001: begin
                ld_bad = ld_offset[0];
                ld_ext = {{(XLEN-16){ld_h[15]}}, ld_h};
            end
            3'b101: begin
                ld_bad = ld_offset[0];
                ld_ext = {{(XLEN-16){1'b0}}, ld_h};
            end
            3'b010: begin
                ld_bad = ld_offset != 2'b00;
                ld_ext = ld_word;
            end
            default: ld_bad = 1'b1;
        endcase
    end

    // Loads always win; a dropped load still blocks the FIFO pop and clears busy.
    assign sel_adr    = ld_valid ? ld_rdadr : adr_q[rp_q];
    assign rd_d       = ld_valid ? ld_ext : data_q[rp_q];
    assign regwrite_d = ld_valid ? (!ld_bad && ld_rdadr != 4'd0) : (pop && adr_q[rp_q] != 4'd0);
    assign set_m      = issue_valid ? (16'd1 << issue_rdadr) : 16'd0;
    assign clr_m      = sel ? (16'd1 << sel_adr) : 16'd0;
    assign busy_d     = ((busy_q & ~clr_m) | set_m) & 16'hFFFE;

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wp_q] <= alu_data;
            adr_q[wp_q]  <= alu_rdadr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            rdadr_q    <= '0;
            rd_q       <= '0;
            ld_err_q   <= 1'b0;
            busy_q     <= '0;
        end else begin
            wp_q       <= wp_q + AW'(push);
            rp_q       <= rp_q + AW'(pop);
            cnt_q      <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            regwrite_q <= regwrite_d;
            ld_err_q   <= ld_valid && ld_bad;
            busy_q     <= busy_d;
            if (sel) begin
                rdadr_q <= sel_adr;
                rd_q    <= rd_d;
            end
        end
    end

    assign regwrite = regwrite_q;
    assign rdadr    = rdadr_q;
    assign rd       = rd_q;
    assign ld_err   = ld_err_q;
    assign busy     = busy_q;

`ifdef REGS_WB_BYPASS_EN
    assign fwd_rs1_hit = regwrite_q && rdadr_q == rs1adr && rdadr_q != 4'd0;
    assign fwd_rs2_hit = regwrite_q && rdadr_q == rs2adr && rdadr_q != 4'd0;
`endif
endmodule
